// File: rtl/pipe_mux_reg.sv
// pipe_mux_reg: N-input registered mux with valid, stall/flush and select-range error; PIPE_MUX_PARITY_EN adds out_parity
module pipe_mux_reg #(
    parameter int WIDTH = 32,
    parameter int NUM_IN = 4,
    parameter int STAGES = 1,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_IN*WIDTH-1:0] IN_BUS,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        OUT,
    output logic                    out_valid,
    output logic                    sel_err
`ifdef PIPE_MUX_PARITY_EN
    ,
    output logic                    out_parity
`endif
);
    logic              sel_ok;
    logic [WIDTH-1:0]  pick;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] e_q;
`ifdef PIPE_MUX_PARITY_EN
    logic [STAGES-1:0] p_q;
    assign out_parity = p_q[STAGES-1];
`endif
    assign sel_ok    = {1'b0, sel} < (SEL_W+1)'(NUM_IN);
    assign pick      = sel_ok ? IN_BUS[sel*WIDTH +: WIDTH] : '0;
    assign OUT       = data_q[STAGES-1];
    assign out_valid = v_q[STAGES-1];
    assign sel_err   = e_q[STAGES-1];
    // stage registers: async clear, flush clears, stall holds, otherwise capture and shift
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            v_q <= '0;
            e_q <= '0;
`ifdef PIPE_MUX_PARITY_EN
            p_q <= '0;
`endif
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
        end else if (flush) begin
            v_q <= '0;
            e_q <= '0;
`ifdef PIPE_MUX_PARITY_EN
            p_q <= '0;
`endif
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
        end else if (!stall) begin
            for (int i = STAGES-1; i > 0; i--) begin
                data_q[i] <= data_q[i-1];
                v_q[i]    <= v_q[i-1];
                e_q[i]    <= e_q[i-1];
`ifdef PIPE_MUX_PARITY_EN
                p_q[i]    <= p_q[i-1];
`endif
            end
            data_q[0] <= pick;
            v_q[0]    <= in_valid;
            e_q[0]    <= in_valid & ~sel_ok;
`ifdef PIPE_MUX_PARITY_EN
            p_q[0]    <= ^pick;
`endif
        end
    end
endmodule
